// File: rtl/rs_stream_if.sv
// Valid/ready stream bundle for rs_stream_decoder: word in, corrected word and flags out.
// err_count exists only when RS_ERR_COUNT_EN is defined.
interface rs_stream_if #(
    parameter int SYMS = 7
);
    localparam int W = 3 * SYMS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] codeword;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] corrected;
    logic         err_det;
    logic         err_fail;
    logic [2:0]   err_pos;

`ifdef RS_ERR_COUNT_EN
    logic [15:0]  err_count;

    modport master (
        output in_valid, codeword, out_ready,
        input  in_ready, out_valid, corrected, err_det, err_fail, err_pos, err_count
    );

    modport slave (
        input  in_valid, codeword, out_ready,
        output in_ready, out_valid, corrected, err_det, err_fail, err_pos, err_count
    );
`else
    modport master (
        output in_valid, codeword, out_ready,
        input  in_ready, out_valid, corrected, err_det, err_fail, err_pos
    );

    modport slave (
        input  in_valid, codeword, out_ready,
        output in_ready, out_valid, corrected, err_det, err_fail, err_pos
    );
`endif
endinterface

// File: rtl/rs_stream_decoder.sv
// Serial single-symbol-error RS decoder over GF(8) (x^3+x+1), two parity symbols, SYMS 3..7.
// Optional saturating error-word counter enabled by defining RS_ERR_COUNT_EN.
module rs_stream_decoder #(
    parameter int SYMS = 7
) (
    input  logic        clk,
    input  logic        reset,
    rs_stream_if.slave  bus
);
    localparam int W = 3 * SYMS;

    typedef enum logic [1:0] {IDLE, SYND, SOLVE, OUT} state_t;

    // Multiply by alpha: x^3 folds back to x + 1.
    function automatic logic [2:0] gf_xtime(input logic [2:0] a);
        return {a[1], a[0] ^ a[2], a[2]};
    endfunction

    function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] p;
        logic [2:0] sh;
        p  = 3'd0;
        sh = a;
        for (int i = 0; i < 3; i++) begin
            if (b[i]) p = p ^ sh;
            sh = gf_xtime(sh);
        end
        return p;
    endfunction

    function automatic logic [2:0] gf_inv(input logic [2:0] a);
        case (a)
            3'd1:    return 3'd1;
            3'd2:    return 3'd5;
            3'd4:    return 3'd7;
            3'd3:    return 3'd6;
            3'd6:    return 3'd3;
            3'd7:    return 3'd4;
            3'd5:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] gf_log(input logic [2:0] a);
        case (a)
            3'd1:    return 3'd0;
            3'd2:    return 3'd1;
            3'd4:    return 3'd2;
            3'd3:    return 3'd3;
            3'd6:    return 3'd4;
            3'd7:    return 3'd5;
            3'd5:    return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    state_t       state;
    logic [W-1:0] word;
    logic [2:0]   cnt;
    logic [2:0]   s1;
    logic [2:0]   s2;
    logic         out_valid_q;
    logic [W-1:0] corrected_q;
    logic         err_det_q;
    logic         err_fail_q;
    logic [2:0]   err_pos_q;

    logic [2:0]   sym;
    logic [2:0]   loc_x;
    logic [2:0]   mag_y;
    logic [2:0]   loc_j;
    logic [W-1:0] fix_word;
    logic [W-1:0] sol_word;
    logic         sol_det;
    logic         sol_fail;
    logic [2:0]   sol_pos;

    assign sym = word[3*cnt +: 3];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        loc_x    = gf_mul(s2, gf_inv(s1));
        mag_y    = gf_mul(gf_mul(s1, s1), gf_inv(s2));
        loc_j    = gf_log(loc_x);
        fix_word = word;
        for (int i = 0; i < SYMS; i++) begin
            if (int'(loc_j) == i) fix_word[3*i +: 3] = word[3*i +: 3] ^ mag_y;
        end

        sol_word = word;
        sol_det  = (s1 != 3'd0) || (s2 != 3'd0);
        sol_fail = 1'b0;
        sol_pos  = 3'd0;
        if (s1 == 3'd0 && s2 == 3'd0) begin
            sol_fail = 1'b0;
        end else if (s1 == 3'd0 || s2 == 3'd0) begin
            sol_fail = 1'b1;
        end else if (int'(loc_j) >= SYMS) begin
            // Locator points into the shortened-away part of the code.
            sol_fail = 1'b1;
        end else begin
            sol_word = fix_word;
            sol_pos  = loc_j;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            word        <= '0;
            cnt         <= 3'd0;
            s1          <= 3'd0;
            s2          <= 3'd0;
            out_valid_q <= 1'b0;
            corrected_q <= '0;
            err_det_q   <= 1'b0;
            err_fail_q  <= 1'b0;
            err_pos_q   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        word  <= bus.codeword;
                        cnt   <= 3'(SYMS - 1);
                        s1    <= 3'd0;
                        s2    <= 3'd0;
                        state <= SYND;
                    end
                end
                SYND: begin
                    // Horner step at alpha and alpha^2, highest symbol first.
                    s1 <= gf_xtime(s1) ^ sym;
                    s2 <= gf_mul(s2, 3'd4) ^ sym;
                    if (cnt == 3'd0) begin
                        state <= SOLVE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                SOLVE: begin
                    corrected_q <= sol_word;
                    err_det_q   <= sol_det;
                    err_fail_q  <= sol_fail;
                    err_pos_q   <= sol_pos;
                    out_valid_q <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !reset;
    assign bus.out_valid = out_valid_q;
    assign bus.corrected = corrected_q;
    assign bus.err_det   = err_det_q;
    assign bus.err_fail  = err_fail_q;
    assign bus.err_pos   = err_pos_q;

`ifdef RS_ERR_COUNT_EN
    logic [15:0] err_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= 16'd0;
        end else if (out_valid_q && bus.out_ready && err_det_q && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign bus.err_count = err_cnt;
`else
    // Counter and its port are absent in this build.
`endif
endmodule

// File: tb/tb_rs_stream_decoder.sv
// Directed self-checking bench for rs_stream_decoder (SYMS=7).
module tb_rs_stream_decoder;
    localparam int SYMS = 7;
    localparam int W    = 3 * SYMS;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    rs_stream_if #(.SYMS(SYMS)) bus ();

    rs_stream_decoder #(.SYMS(SYMS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] cw;
        logic [W-1:0] exp_word;
        logic         exp_det;
        logic         exp_fail;
        logic [2:0]   exp_pos;
    } vec_t;

    task automatic accept(input logic [W-1:0] cw);
        int n = 0;
        bus.codeword = cw;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1;
        bus.codeword = 21'h000140;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.corrected !== 21'h0) begin errors++; $display("FAIL reset_corrected: got %h want 0", bus.corrected); end
        checks++; if ({bus.err_det, bus.err_fail, bus.err_pos} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got det=%b fail=%b pos=%0d want 0", bus.err_det, bus.err_fail, bus.err_pos);
        end
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_in_valid_ignored: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_decode();
        vec_t vecs [4];
        int   n;
        vecs[0] = '{cw: 21'h000073, exp_word: 21'h000073, exp_det: 1'b0, exp_fail: 1'b0, exp_pos: 3'd0};
        vecs[1] = '{cw: 21'h000140, exp_word: 21'h000000, exp_det: 1'b1, exp_fail: 1'b0, exp_pos: 3'd2};
        vecs[2] = '{cw: 21'h00000A, exp_word: 21'h00000A, exp_det: 1'b1, exp_fail: 1'b1, exp_pos: 3'd0};
        vecs[3] = '{cw: 21'h038073, exp_word: 21'h000073, exp_det: 1'b1, exp_fail: 1'b0, exp_pos: 3'd5};
        for (int k = 0; k < 4; k++) begin
            accept(vecs[k].cw);
            wait_out(n);
            checks++; if (n != SYMS + 1) begin errors++; $display("FAIL decode%0d_latency: got %0d want %0d", k, n, SYMS + 1); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL decode%0d_busy: in_ready=%b want 0", k, bus.in_ready); end
            checks++; if (bus.corrected !== vecs[k].exp_word) begin
                errors++; $display("FAIL decode%0d_corrected: got %h want %h", k, bus.corrected, vecs[k].exp_word);
            end
            checks++; if (bus.err_det !== vecs[k].exp_det) begin
                errors++; $display("FAIL decode%0d_err_det: got %b want %b", k, bus.err_det, vecs[k].exp_det);
            end
            checks++; if (bus.err_fail !== vecs[k].exp_fail) begin
                errors++; $display("FAIL decode%0d_err_fail: got %b want %b", k, bus.err_fail, vecs[k].exp_fail);
            end
            checks++; if (bus.err_pos !== vecs[k].exp_pos) begin
                errors++; $display("FAIL decode%0d_err_pos: got %0d want %0d", k, bus.err_pos, vecs[k].exp_pos);
            end
            handshake();
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL decode%0d_after_hs: out_valid=%b in_ready=%b want 0 1", k, bus.out_valid, bus.in_ready);
            end
            checks++; if (bus.corrected !== vecs[k].exp_word) begin
                errors++; $display("FAIL decode%0d_hold: got %h want %h", k, bus.corrected, vecs[k].exp_word);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [26:0] exp_out;
        exp_out = {1'b1, 21'h000000, 1'b1, 1'b0, 3'd2};
        accept(21'h000140);
        wait_out(n);
        checks++; if (n != SYMS + 1) begin errors++; $display("FAIL bp_latency: got %0d want %0d", n, SYMS + 1); end
        bus.codeword = 21'h000073;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if ({bus.out_valid, bus.corrected, bus.err_det, bus.err_fail, bus.err_pos} !== exp_out) begin
                errors++; $display("FAIL bp_stable%0d: got %h want %h", c,
                    {bus.out_valid, bus.corrected, bus.err_det, bus.err_fail, bus.err_pos}, exp_out);
            end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b want 0", c, bus.in_ready); end
        end
        handshake();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_handshake: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept: in_ready=%b want 0", bus.in_ready); end
        wait_out(n);
        checks++; if (n != SYMS + 1) begin errors++; $display("FAIL bp_second_latency: got %0d want %0d", n, SYMS + 1); end
        checks++; if (bus.corrected !== 21'h000073 || bus.err_det !== 1'b0) begin
            errors++; $display("FAIL bp_second_word: got %h det=%b want 000073 det=0", bus.corrected, bus.err_det);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        int   n;
        logic seen;
        accept(21'h038073);
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        checks++; if ({bus.out_valid, bus.corrected, bus.err_det, bus.err_fail, bus.err_pos} !== 27'd0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h want 0",
                {bus.out_valid, bus.corrected, bus.err_det, bus.err_fail, bus.err_pos});
        end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_in_ready: got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_aborted: out_valid seen=%b want 0", seen); end
        accept(21'h000140);
        wait_out(n);
        checks++; if (n != SYMS + 1) begin errors++; $display("FAIL mid_reset_next_latency: got %0d want %0d", n, SYMS + 1); end
        checks++; if (bus.corrected !== 21'h0 || bus.err_pos !== 3'd2 || bus.err_fail !== 1'b0) begin
            errors++; $display("FAIL mid_reset_next_word: got %h pos=%0d fail=%b want 0 pos=2 fail=0",
                bus.corrected, bus.err_pos, bus.err_fail);
        end
        handshake();
    endtask

`ifdef RS_ERR_COUNT_EN
    task automatic test_err_count();
        int n;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (bus.err_count !== 16'd0) begin errors++; $display("FAIL cnt_reset: got %0d want 0", bus.err_count); end
        accept(21'h000140); wait_out(n); handshake();
        accept(21'h000073); wait_out(n); handshake();
        accept(21'h00000A); wait_out(n); handshake();
        checks++; if (bus.err_count !== 16'd2) begin errors++; $display("FAIL cnt_three_words: got %0d want 2", bus.err_count); end
        force dut.err_cnt = 16'hFFFE;
        @(posedge clk); #1;
        release dut.err_cnt;
        accept(21'h000140); wait_out(n); handshake();
        checks++; if (bus.err_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_to_max: got %h want ffff", bus.err_count); end
        accept(21'h00000A); wait_out(n); handshake();
        checks++; if (bus.err_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate: got %h want ffff", bus.err_count); end
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.codeword  = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_decode();
        test_backpressure();
        test_reset_mid();
`ifdef RS_ERR_COUNT_EN
        test_err_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
